// File: rtl/ahb_mem_responder.sv
// ahb_mem_responder: AHB-Lite word-memory slave with NONSEQ wait states and burst legality checking
module ahb_mem_responder #(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 2
) (
    input  logic        hclk,
    input  logic        hrst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hburst,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic [31:0] hrdata,
    output logic        hresp
);
    localparam int          AW   = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;
    localparam logic [3:0]  WS   = 4'(WAIT_STATES);

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
    state_t state, state_nx;

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] idx;
    logic          wr;
    logic [3:0]    wcnt, wcnt_nx;
    logic [1:0]    beat;
    logic          burst_on;
    logic [2:0]    burst;
    logic [31:0]   prev;
    logic [32:0]   off;
    logic          accept, seq, seq_ok, legal;

    assign accept = hsel && hready && hreadyout && htrans[1];
    assign seq    = htrans[0];
    assign off    = {1'b0, haddr} - {1'b0, BASE_ADDR};
    // a SEQ must continue an accepted WRAP4/INCR/INCR4 burst; the fixed-length kinds stop after 4 beats
    assign seq_ok = burst_on && !(burst[1] && beat == 2'd3) &&
                    haddr == (burst == 3'd2 ? {prev[31:4], prev[3:2] + 2'd1, 2'b00} : prev + 32'd4);
    assign legal  = off < SPAN && haddr[1:0] == 2'b00 && hsize == 3'b010 && (!seq || seq_ok);

    always_comb begin
        state_nx  = IDLE;
        wcnt_nx   = wcnt == 4'd0 ? 4'd0 : wcnt - 4'd1;
        hreadyout = state != WAIT && state != ERR1;
        hresp     = state == ERR1 || state == ERR2;
        hrdata    = state == DATA && !wr ? mem[idx] : 32'h0;
        if (state == WAIT)
            state_nx = wcnt == 4'd0 ? DATA : WAIT;
        else if (state == ERR1)
            state_nx = ERR2;
        else if (accept) begin
            state_nx = !legal ? ERR1 : (!seq && WS != 4'd0) ? WAIT : DATA;
            wcnt_nx  = legal && !seq && WS != 4'd0 ? WS - 4'd1 : 4'd0;
        end
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state    <= IDLE;
            wcnt     <= 4'd0;
            beat     <= 2'd0;
            burst_on <= 1'b0;
            burst    <= 3'd0;
            prev     <= 32'd0;
            idx      <= '0;
            wr       <= 1'b0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            if (accept) begin
                idx      <= AW'(off >> 2);
                wr       <= hwrite;
                // an ERROR ends the burst, so only a fresh NONSEQ can restart it
                burst_on <= legal && (seq || (hburst != 3'd0 && !hburst[2]));
                burst    <= legal && !seq ? hburst : burst;
                beat     <= legal && seq ? beat + 2'd1 : 2'd0;
                prev     <= legal ? haddr : 32'd0;
            end
        end
    end

    always_ff @(posedge hclk)
        if (state == DATA && wr)
            mem[idx] <= hwdata;
endmodule

// File: tb/tb_ahb_mem_responder.sv
// tb_ahb_mem_responder: randomized self-checking bench comparing the responder to a transfer-level model
module tb_ahb_mem_responder;
    localparam int          WORDS = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          WS    = 2;
    localparam int          MAXX  = 512;

    logic        hclk   = 1'b0;
    logic        hrst   = 1'b1;
    logic        hsel   = 1'b0;
    logic [31:0] haddr  = '0;
    logic [1:0]  htrans = 2'd0;
    logic [2:0]  hburst = 3'd0;
    logic [2:0]  hsize  = 3'b010;
    logic        hwrite = 1'b0;
    logic [31:0] hwdata = '0;
    logic        hready, hreadyout, hresp;
    logic [31:0] hrdata;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [2:0]  size;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       xq[$];
    int          e_wait[MAXX], o_wait[MAXX];
    logic        e_resp[MAXX], o_resp[MAXX], e_wresp[MAXX], o_wresp[MAXX];
    logic [31:0] e_rdata[MAXX], o_rdata[MAXX], o_idle[MAXX];
    logic [31:0] mm[WORDS];
    logic        ctx_on   = 1'b0;
    logic [2:0]  ctx_kind = 3'd0;
    logic [31:0] ctx_last = '0;
    int          ctx_cnt  = 0;
    int          passed   = 0;
    int          total    = 0;

    assign hready = hreadyout;
    always #5 hclk = ~hclk;

    ahb_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
        .hclk(hclk), .hrst(hrst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hburst(hburst),
        .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
        .hreadyout(hreadyout), .hrdata(hrdata), .hresp(hresp)
    );

    function automatic void add(input logic sel, input logic [1:0] trans, input logic [2:0] burst,
                                input logic [2:0] size, input logic write, input logic [31:0] addr,
                                input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.burst = burst; x.size = size;
        x.write = write; x.addr = addr; x.wdata = wdata;
        xq.push_back(x);
    endfunction

    // Transfer-level model: each entry of xq yields its expected stall count, response and read data.
    function automatic void model_run();
        xfer_t       x;
        logic        ok;
        logic [31:0] nxt;
        for (int k = 0; k < xq.size(); k++) begin
            x = xq[k];
            e_wait[k] = 0; e_resp[k] = 1'b0; e_wresp[k] = 1'b0; e_rdata[k] = '0;
            if (x.sel && (x.trans == 2'd2 || x.trans == 2'd3)) begin
                ok = x.addr >= BASE && x.addr < BASE + 32'(4 * WORDS) && x.addr % 4 == 0 && x.size == 3'b010;
                if (x.trans == 2'd3) begin
                    nxt = ctx_kind == 3'd2 ? (ctx_last & ~32'hF) | ((ctx_last + 32'd4) & 32'hC) : ctx_last + 32'd4;
                    ok = ok && ctx_on && x.addr == nxt && !(ctx_kind != 3'd1 && ctx_cnt >= 4);
                end
                if (!ok) begin
                    ctx_on = 1'b0; ctx_cnt = 0;
                    e_wait[k] = 1; e_resp[k] = 1'b1; e_wresp[k] = 1'b1;
                end else begin
                    if (x.trans == 2'd2) begin
                        ctx_on = x.burst inside {3'd1, 3'd2, 3'd3};
                        ctx_kind = x.burst; ctx_cnt = 1; e_wait[k] = WS;
                    end else
                        ctx_cnt++;
                    ctx_last = x.addr;
                    if (x.write) mm[(x.addr - BASE) / 4] = x.wdata;
                    else e_rdata[k] = mm[(x.addr - BASE) / 4];
                end
            end
        end
    endfunction

    // Pipelined bus driver: entered and left just after a rising edge; records per-entry data-phase observations.
    task automatic drive();
        int   i = 0, d = -1, cyc = 0;
        logic ro;
        for (int k = 0; k < xq.size(); k++) begin
            o_wait[k] = 0; o_wresp[k] = 1'b0; o_idle[k] = '0; o_resp[k] = 1'bx; o_rdata[k] = 'x;
        end
        while ((i < xq.size() || d >= 0) && cyc < 8 * xq.size() + 20) begin
            if (i < xq.size()) begin
                hsel = xq[i].sel; htrans = xq[i].trans; hburst = xq[i].burst;
                hsize = xq[i].size; hwrite = xq[i].write; haddr = xq[i].addr;
            end else begin
                hsel = 1'b0; htrans = 2'd0;
            end
            hwdata = d >= 0 ? xq[d].wdata : 32'h0;
            ro = hreadyout;
            if (d >= 0 && !ro) begin
                o_wait[d]++; o_wresp[d] = o_wresp[d] | hresp; o_idle[d] = o_idle[d] | hrdata;
            end else if (d >= 0) begin
                o_resp[d] = hresp; o_rdata[d] = hrdata;
            end
            if (ro) begin
                d = i < xq.size() ? i : -1;
                if (i < xq.size()) i++;
            end
            @(posedge hclk);
            #1;
            cyc++;
        end
        hsel = 1'b0; htrans = 2'd0;
        total++;
        if (i < xq.size() || d >= 0) $display("FAIL drive_timeout got %0d of %0d entries issued", i, xq.size());
        else passed++;
    endtask

    task automatic test_reset();
        hrst = 1'b1;
        repeat (2) @(posedge hclk);
        #1;
        total++; if (hreadyout !== 1'b1) $display("FAIL reset_hreadyout got %b want 1", hreadyout); else passed++;
        total++; if (hresp !== 1'b0) $display("FAIL reset_hresp got %b want 0", hresp); else passed++;
        total++; if (hrdata !== 32'h0) $display("FAIL reset_hrdata got %h want 0", hrdata); else passed++;
        hrst = 1'b0;
        ctx_on = 1'b0; ctx_cnt = 0;
    endtask

    task automatic test_fill();
        xq.delete();
        for (int w = 0; w < WORDS; w++)
            add(1'b1, w % 4 == 0 ? 2'd2 : 2'd3, 3'd3, 3'd2, 1'b1, BASE + 32'(4 * w), $urandom);
        model_run();
        drive();
        for (int k = 0; k < xq.size(); k++) begin
            total++;
            if (o_wait[k] != e_wait[k] || o_resp[k] !== e_resp[k] || o_wresp[k] !== e_wresp[k] || o_rdata[k] !== e_rdata[k] || o_idle[k] !== 32'h0)
                $display("FAIL fill[%0d] got wait=%0d resp=%b/%b rdata=%h stall_rdata=%h want wait=%0d resp=%b/%b rdata=%h stall_rdata=0",
                         k, o_wait[k], o_wresp[k], o_resp[k], o_rdata[k], o_idle[k], e_wait[k], e_wresp[k], e_resp[k], e_rdata[k]);
            else passed++;
        end
    endtask

    task automatic test_single();
        xq.delete();
        add(1'b1, 2'd2, 3'd0, 3'd2, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF);
        add(1'b1, 2'd2, 3'd0, 3'd2, 1'b0, BASE + 32'h10, 32'h0);
        model_run();
        drive();
        for (int k = 0; k < xq.size(); k++) begin
            total++;
            if (o_wait[k] != e_wait[k] || o_resp[k] !== e_resp[k] || o_wresp[k] !== e_wresp[k] || o_rdata[k] !== e_rdata[k] || o_idle[k] !== 32'h0)
                $display("FAIL single[%0d] got wait=%0d resp=%b/%b rdata=%h stall_rdata=%h want wait=%0d resp=%b/%b rdata=%h stall_rdata=0",
                         k, o_wait[k], o_wresp[k], o_resp[k], o_rdata[k], o_idle[k], e_wait[k], e_wresp[k], e_resp[k], e_rdata[k]);
            else passed++;
        end
        total++;
        if (o_wait[0] != 2 || o_wait[1] != 2 || o_rdata[1] !== 32'hDEAD_BEEF || o_resp[1] !== 1'b0)
            $display("FAIL single_readback got waits=%0d/%0d rdata=%h resp=%b want waits=2/2 rdata=deadbeef resp=0",
                     o_wait[0], o_wait[1], o_rdata[1], o_resp[1]);
        else passed++;
    endtask

    task automatic test_wrap();
        xq.delete();
        add(1'b1, 2'd2, 3'd2, 3'd2, 1'b0, BASE + 32'h18, 32'h0);
        add(1'b1, 2'd3, 3'd2, 3'd2, 1'b0, BASE + 32'h1C, 32'h0);
        add(1'b1, 2'd3, 3'd2, 3'd2, 1'b0, BASE + 32'h10, 32'h0);
        add(1'b1, 2'd3, 3'd2, 3'd2, 1'b0, BASE + 32'h14, 32'h0);
        add(1'b1, 2'd3, 3'd2, 3'd2, 1'b0, BASE + 32'h18, 32'h0);
        model_run();
        drive();
        for (int k = 0; k < xq.size(); k++) begin
            total++;
            if (o_wait[k] != e_wait[k] || o_resp[k] !== e_resp[k] || o_wresp[k] !== e_wresp[k] || o_rdata[k] !== e_rdata[k] || o_idle[k] !== 32'h0)
                $display("FAIL wrap[%0d] got wait=%0d resp=%b/%b rdata=%h stall_rdata=%h want wait=%0d resp=%b/%b rdata=%h stall_rdata=0",
                         k, o_wait[k], o_wresp[k], o_resp[k], o_rdata[k], o_idle[k], e_wait[k], e_wresp[k], e_resp[k], e_rdata[k]);
            else passed++;
        end
    endtask

    task automatic test_wrap_err();
        xq.delete();
        add(1'b1, 2'd2, 3'd2, 3'd2, 1'b1, BASE + 32'h18, 32'h1111_0018);
        add(1'b1, 2'd3, 3'd2, 3'd2, 1'b1, BASE + 32'h20, 32'h2222_0020);
        add(1'b1, 2'd3, 3'd2, 3'd2, 1'b1, BASE + 32'h24, 32'h3333_0024);
        add(1'b1, 2'd2, 3'd0, 3'd2, 1'b0, BASE + 32'h20, 32'h0);
        add(1'b1, 2'd2, 3'd0, 3'd2, 1'b0, BASE + 32'h24, 32'h0);
        model_run();
        drive();
        for (int k = 0; k < xq.size(); k++) begin
            total++;
            if (o_wait[k] != e_wait[k] || o_resp[k] !== e_resp[k] || o_wresp[k] !== e_wresp[k] || o_rdata[k] !== e_rdata[k] || o_idle[k] !== 32'h0)
                $display("FAIL wrap_err[%0d] got wait=%0d resp=%b/%b rdata=%h stall_rdata=%h want wait=%0d resp=%b/%b rdata=%h stall_rdata=0",
                         k, o_wait[k], o_wresp[k], o_resp[k], o_rdata[k], o_idle[k], e_wait[k], e_wresp[k], e_resp[k], e_rdata[k]);
            else passed++;
        end
    endtask

    task automatic test_illegal();
        xq.delete();
        add(1'b1, 2'd2, 3'd0, 3'd2, 1'b0, BASE + 32'(4 * WORDS), 32'h0);
        add(1'b1, 2'd2, 3'd0, 3'd2, 1'b0, BASE + 32'h2, 32'h0);
        add(1'b1, 2'd2, 3'd0, 3'd1, 1'b0, BASE + 32'h8, 32'h0);
        add(1'b1, 2'd2, 3'd0, 3'd2, 1'b0, BASE - 32'h4, 32'h0);
        add(1'b1, 2'd2, 3'd0, 3'd2, 1'b0, BASE + 32'h8, 32'h0);
        model_run();
        drive();
        for (int k = 0; k < xq.size(); k++) begin
            total++;
            if (o_wait[k] != e_wait[k] || o_resp[k] !== e_resp[k] || o_wresp[k] !== e_wresp[k] || o_rdata[k] !== e_rdata[k] || o_idle[k] !== 32'h0)
                $display("FAIL illegal[%0d] got wait=%0d resp=%b/%b rdata=%h stall_rdata=%h want wait=%0d resp=%b/%b rdata=%h stall_rdata=0",
                         k, o_wait[k], o_wresp[k], o_resp[k], o_rdata[k], o_idle[k], e_wait[k], e_wresp[k], e_resp[k], e_rdata[k]);
            else passed++;
        end
    endtask

    task automatic test_reset_wait();
        hsel = 1'b1; htrans = 2'd2; hburst = 3'd0; hsize = 3'b010; hwrite = 1'b1; haddr = BASE + 32'h40;
        @(posedge hclk);
        #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = 32'hBAD0_0040;
        total++; if (hreadyout !== 1'b0) $display("FAIL rst_wait_stall got hreadyout=%b want 0", hreadyout); else passed++;
        hrst = 1'b1;
        #1;
        total++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0)
            $display("FAIL rst_wait_async got ready=%b resp=%b rdata=%h want 1 0 0", hreadyout, hresp, hrdata);
        else passed++;
        @(posedge hclk);
        #1;
        hrst = 1'b0;
        ctx_on = 1'b0; ctx_cnt = 0;
        xq.delete();
        add(1'b1, 2'd2, 3'd0, 3'd2, 1'b0, BASE + 32'h40, 32'h0);
        model_run();
        drive();
        for (int k = 0; k < xq.size(); k++) begin
            total++;
            if (o_wait[k] != e_wait[k] || o_resp[k] !== e_resp[k] || o_wresp[k] !== e_wresp[k] || o_rdata[k] !== e_rdata[k] || o_idle[k] !== 32'h0)
                $display("FAIL rst_wait[%0d] got wait=%0d resp=%b/%b rdata=%h stall_rdata=%h want wait=%0d resp=%b/%b rdata=%h stall_rdata=0",
                         k, o_wait[k], o_wresp[k], o_resp[k], o_rdata[k], o_idle[k], e_wait[k], e_wresp[k], e_resp[k], e_rdata[k]);
            else passed++;
        end
    endtask

    task automatic test_no_xfer();
        xq.delete();
        add(1'b0, 2'd2, 3'd0, 3'd2, 1'b1, BASE + 32'h30, 32'h5555_0030);
        add(1'b1, 2'd1, 3'd0, 3'd2, 1'b1, BASE + 32'h30, 32'h6666_0030);
        add(1'b1, 2'd0, 3'd0, 3'd2, 1'b1, BASE + 32'h30, 32'h7777_0030);
        add(1'b1, 2'd2, 3'd0, 3'd2, 1'b0, BASE + 32'h30, 32'h0);
        model_run();
        drive();
        for (int k = 0; k < xq.size(); k++) begin
            total++;
            if (o_wait[k] != e_wait[k] || o_resp[k] !== e_resp[k] || o_wresp[k] !== e_wresp[k] || o_rdata[k] !== e_rdata[k] || o_idle[k] !== 32'h0)
                $display("FAIL no_xfer[%0d] got wait=%0d resp=%b/%b rdata=%h stall_rdata=%h want wait=%0d resp=%b/%b rdata=%h stall_rdata=0",
                         k, o_wait[k], o_wresp[k], o_resp[k], o_rdata[k], o_idle[k], e_wait[k], e_wresp[k], e_resp[k], e_rdata[k]);
            else passed++;
        end
    endtask

    task automatic test_random();
        int          kind, beats;
        logic [31:0] a;
        xq.delete();
        repeat (20) begin
            kind  = int'($urandom_range(0, 3));
            beats = int'($urandom_range(1, kind == 0 ? 2 : 6));
            a     = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 14) == 0) a = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 3));
            for (int b = 0; b < beats; b++) begin
                add(1'b1, b == 0 ? 2'd2 : 2'd3, 3'(kind), $urandom_range(0, 19) == 0 ? 3'b001 : 3'b010,
                    1'($urandom_range(0, 1)), a, $urandom);
                if ($urandom_range(0, 7) == 0)
                    add(1'($urandom_range(0, 1)), 2'd1, 3'(kind), 3'b010, 1'b1, a, $urandom);
                a = kind == 2 ? (a & ~32'hF) | ((a + 32'd4) & 32'hC) : a + 32'd4;
                if ($urandom_range(0, 11) == 0) a = a + 32'(4 * $urandom_range(1, 3));
            end
        end
        model_run();
        drive();
        for (int k = 0; k < xq.size(); k++) begin
            total++;
            if (o_wait[k] != e_wait[k] || o_resp[k] !== e_resp[k] || o_wresp[k] !== e_wresp[k] || o_rdata[k] !== e_rdata[k] || o_idle[k] !== 32'h0)
                $display("FAIL random[%0d] addr=%h got wait=%0d resp=%b/%b rdata=%h stall_rdata=%h want wait=%0d resp=%b/%b rdata=%h stall_rdata=0",
                         k, xq[k].addr, o_wait[k], o_wresp[k], o_resp[k], o_rdata[k], o_idle[k], e_wait[k], e_wresp[k], e_resp[k], e_rdata[k]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_single();
        test_wrap();
        test_wrap_err();
        test_illegal();
        test_reset_wait();
        test_no_xfer();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ahb_mem_responder.md
AHB_MEM_RESPONDER -- requirements
Module: ahb_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: number of 32-bit words in the internal memory.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; SHALL be 16-byte aligned.
REQ-003 SHALL have parameter WAIT_STATES, default 2: number of wait cycles inserted on each NONSEQ data phase (0..15).
REQ-004 SHALL have ports:
  hclk       in   1   clock; all state updates on the rising edge
  hrst       in   1   reset, asynchronous, active-high
  hsel       in   1   slave select
  haddr      in   32  byte address
  htrans     in   2   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
  hburst     in   3   SINGLE=0, INCR=1, WRAP4=2, INCR4=3
  hsize      in   3   transfer size; only 3'b010 (word) is legal
  hwrite     in   1   1 = write
  hwdata     in   32  write data, valid in the data phase
  hready     in   1   bus-level ready (previous data phase complete)
  hreadyout  out  1   this slave's data-phase ready
  hrdata     out  32  read data
  hresp      out  1   0 = OKAY, 1 = ERROR

Function
REQ-005 SHALL accept an address phase when hsel=1, hready=1 and htrans is NONSEQ or SEQ, registering haddr, hwrite, hburst and a legality flag.
REQ-006 SHALL treat IDLE or BUSY with hsel=1 and hready=1, and any cycle with hsel=0, as no transfer: the next data phase is zero-wait OKAY.
REQ-007 SHALL use FSM states IDLE, WAIT, DATA, ERR1, ERR2.
REQ-008 An accepted legal NONSEQ SHALL go to WAIT when WAIT_STATES>0, else directly to DATA.
REQ-009 WAIT SHALL hold hreadyout=0 for exactly WAIT_STATES cycles, counted by a 4-bit down-counter, then go to DATA.
REQ-010 An accepted legal SEQ SHALL go directly to DATA, with zero wait states.
REQ-011 DATA SHALL drive hreadyout=1 and hresp=0.
  - Read: hrdata = mem[(addr-BASE_ADDR)>>2].
  - Write: hwdata is written to that word on the completing edge.
REQ-012 A transfer SHALL be illegal if any of these hold: addr outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS); addr[1:0]!=0; hsize!=3'b010.
REQ-013 A transfer SHALL also be illegal if it is a SEQ beat of a WRAP4 burst whose address differs from the expected address: previous addr[31:4], with addr[3:2] = previous addr[3:2]+1 mod 4.
REQ-014 A transfer SHALL also be illegal if it is a SEQ beat of an INCR or INCR4 burst whose address is not previous address + 4.
REQ-015 A transfer SHALL also be illegal if it is a SEQ with no preceding accepted NONSEQ or SEQ in the same burst.
REQ-016 An illegal transfer SHALL produce a two-cycle ERROR: ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1). Illegal writes SHALL NOT modify memory.
REQ-017 SHALL track burst beats with a 2-bit counter. For WRAP4/INCR4, a SEQ beyond beat 4 SHALL be illegal.
REQ-018 hrdata SHALL be 32'h0 in every cycle except a read DATA cycle.
REQ-019 A new address phase SHALL be accepted in the same cycle that DATA or ERR2 completes (pipelined). While hreadyout=0, no address phase SHALL be accepted.
REQ-020 A write completing at edge N followed by a read of the same word SHALL return the newly written value.
REQ-021 An ERROR SHALL terminate the burst: the beat counter and expected address SHALL be cleared, so a following SEQ is illegal unless a NONSEQ is accepted first.

Reset
REQ-022 While hrst=1: FSM=IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, beat counter=0, burst-active flag=0.
REQ-023 Reset asserted mid-WAIT or mid-ERR1 SHALL abandon the transfer; a pending write SHALL NOT be committed.
REQ-024 Memory contents SHALL NOT be cleared by reset.
REQ-025 After hrst deasserts, the first rising edge SHALL be able to accept an address phase.

Verification
REQ-026 SHALL cover: NONSEQ SINGLE write 32'hDEAD_BEEF to BASE+0x10 (WAIT_STATES=2), then NONSEQ read of the same address -> write data phase hreadyout low 2 cycles; read hrdata=32'hDEAD_BEEF after 2 wait cycles, hresp=0.
REQ-027 SHALL cover: WRAP4 read NONSEQ 0x18 then SEQ 0x1C, 0x10, 0x14 -> first beat 2 waits, then 3 back-to-back zero-wait beats with the correct words.
REQ-028 SHALL cover: WRAP4 NONSEQ 0x18 then SEQ 0x20 -> second beat gives ERR1/ERR2 (hresp=1, hreadyout 0 then 1); memory unchanged; following SEQ also errors.
REQ-029 SHALL cover: read at BASE+4*MEM_WORDS, read at BASE+0x2, and hsize=3'b001 -> each gives a two-cycle ERROR, hrdata=0.
REQ-030 SHALL cover: hrst pulsed during the WAIT of a write to 0x40 -> outputs return to reset values immediately; later read of 0x40 returns the prior value.
REQ-031 SHALL cover: hsel=0 with htrans=NONSEQ, and htrans=BUSY with hsel=1 -> no memory access; hreadyout=1, hresp=0.
